// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with flush, downstream stall and load-use bubble insertion.
// Load-use detection and the bubble counter are built only when HAZARD_DETECT_EN is defined.
module id_ex_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegDst,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        MemRead,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        ALUSrc,
  input  logic        RegWrite,
  input  logic        lui,
  input  logic        jump,
  input  logic [2:0]  ALUOp,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] SignExtImm,
  input  logic [31:0] PC_4,
  input  logic        flush,
  input  logic        stall_in,
  output logic        RegDst_ex,
  output logic        BranchEQ_ex,
  output logic        BranchNE_ex,
  output logic        MemRead_ex,
  output logic        MemtoReg_ex,
  output logic        MemWrite_ex,
  output logic        ALUSrc_ex,
  output logic        RegWrite_ex,
  output logic        lui_ex,
  output logic        jump_ex,
  output logic [2:0]  ALUOp_ex,
  output logic        ex_valid,
  output logic [4:0]  id_rs_ex,
  output logic [4:0]  id_rt_ex,
  output logic [4:0]  id_rd_ex,
  output logic [31:0] ReadData1_ex,
  output logic [31:0] ReadData2_ex,
  output logic [31:0] SignExtImm_ex,
  output logic [31:0] PC_4_ex,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic [15:0] bubble_cnt
);
  logic [12:0] ctrlIn, ctrlQ;
  logic hazard, advance, killCtrl;
  assign ctrlIn = {RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, lui, jump, ALUOp};
  assign {RegDst_ex, BranchEQ_ex, BranchNE_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex, lui_ex, jump_ex, ALUOp_ex} = ctrlQ;
`ifdef HAZARD_DETECT_EN
  assign hazard = MemRead_ex & ex_valid & id_valid & (id_rt_ex != 5'd0) & ((id_rt_ex == id_rs) | (id_rt_ex == id_rt));
`else
  assign hazard = 1'b0;
`endif
  // A flush overrides the stall; a hazard only matters when neither flush nor stall is active.
  assign advance   = flush | ~stall_in;
  assign killCtrl  = flush | hazard;
  assign PCWrite   = reset | flush | (~stall_in & ~hazard);
  assign IFIDWrite = PCWrite;
  // EX-stage state: data always follows ID when advancing, control is zeroed for bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlQ         <= '0;
      ex_valid      <= 1'b0;
      id_rs_ex      <= '0;
      id_rt_ex      <= '0;
      id_rd_ex      <= '0;
      ReadData1_ex  <= '0;
      ReadData2_ex  <= '0;
      SignExtImm_ex <= '0;
      PC_4_ex       <= '0;
    end else if (advance) begin
      ctrlQ         <= killCtrl ? '0 : ctrlIn;
      ex_valid      <= ~killCtrl & id_valid;
      id_rs_ex      <= id_rs;
      id_rt_ex      <= id_rt;
      id_rd_ex      <= id_rd;
      ReadData1_ex  <= ReadData1;
      ReadData2_ex  <= ReadData2;
      SignExtImm_ex <= SignExtImm;
      PC_4_ex       <= PC_4;
    end
  end
`ifdef HAZARD_DETECT_EN
  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk) begin
    if (reset) bubble_cnt <= '0;
    else if (~flush & ~stall_in & hazard & (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
  end
`else
  assign bubble_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: randomized and directed checks of id_ex_register against a behavioural model.
module tb_id_ex_register;
  logic clk = 1'b0;
  logic reset, RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, lui, jump;
  logic [2:0] ALUOp;
  logic id_valid, flush, stall_in;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [31:0] ReadData1, ReadData2, SignExtImm, PC_4;
  logic RegDst_ex, BranchEQ_ex, BranchNE_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex, lui_ex, jump_ex;
  logic [2:0] ALUOp_ex;
  logic ex_valid, PCWrite, IFIDWrite;
  logic [4:0] id_rs_ex, id_rt_ex, id_rd_ex;
  logic [31:0] ReadData1_ex, ReadData2_ex, SignExtImm_ex, PC_4_ex;
  logic [15:0] bubble_cnt;
  int tests = 0, fails = 0;
`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  always #5 clk = ~clk;
  id_ex_register dut (
    .clk(clk), .reset(reset), .RegDst(RegDst), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .lui(lui), .jump(jump),
    .ALUOp(ALUOp), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .SignExtImm(SignExtImm), .PC_4(PC_4), .flush(flush), .stall_in(stall_in),
    .RegDst_ex(RegDst_ex), .BranchEQ_ex(BranchEQ_ex), .BranchNE_ex(BranchNE_ex), .MemRead_ex(MemRead_ex),
    .MemtoReg_ex(MemtoReg_ex), .MemWrite_ex(MemWrite_ex), .ALUSrc_ex(ALUSrc_ex), .RegWrite_ex(RegWrite_ex),
    .lui_ex(lui_ex), .jump_ex(jump_ex), .ALUOp_ex(ALUOp_ex), .ex_valid(ex_valid), .id_rs_ex(id_rs_ex),
    .id_rt_ex(id_rt_ex), .id_rd_ex(id_rd_ex), .ReadData1_ex(ReadData1_ex), .ReadData2_ex(ReadData2_ex),
    .SignExtImm_ex(SignExtImm_ex), .PC_4_ex(PC_4_ex), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .bubble_cnt(bubble_cnt)
  );
  // Model of the EX-stage contents, kept as named fields.
  typedef struct {
    logic [12:0] ctrl;
    logic        memRead;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm, pc4;
    logic        valid;
    int          bubbles;
  } ex_t;
  ex_t m;
  function automatic logic [12:0] ctrlInputs();
    return {RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, lui, jump, ALUOp};
  endfunction
  function automatic bit loadUse();
    return HZ && m.memRead && m.valid && id_valid && m.rt != 5'd0 && (m.rt == id_rs || m.rt == id_rt);
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // One clock: check front-end enables, advance the model at the edge, then check the registers.
  task automatic cycle();
    bit hz, wr;
    #1;
    hz = loadUse();
    wr = reset || flush || (!stall_in && !hz);
    chk("PCWrite", PCWrite, wr);
    chk("IFIDWrite", IFIDWrite, wr);
    @(posedge clk);
    if (reset) begin
      m = '{ctrl: 0, memRead: 0, rs: 0, rt: 0, rd: 0, rd1: 0, rd2: 0, imm: 0, pc4: 0, valid: 0, bubbles: 0};
    end else if (flush || !stall_in) begin
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.rd1 = ReadData1; m.rd2 = ReadData2; m.imm = SignExtImm; m.pc4 = PC_4;
      m.ctrl = (flush || hz) ? 13'd0 : ctrlInputs();
      m.memRead = (flush || hz) ? 1'b0 : MemRead;
      m.valid = (flush || hz) ? 1'b0 : id_valid;
      if (!flush && hz && m.bubbles < 65535) m.bubbles++;
    end
    @(negedge clk);
    chk("ctrl_ex", {RegDst_ex, BranchEQ_ex, BranchNE_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex,
                    RegWrite_ex, lui_ex, jump_ex, ALUOp_ex}, m.ctrl);
    chk("regs_ex", {id_rs_ex, id_rt_ex, id_rd_ex}, {m.rs, m.rt, m.rd});
    chk("data_ex", {ReadData1_ex, ReadData2_ex, SignExtImm_ex, PC_4_ex}, {m.rd1, m.rd2, m.imm, m.pc4});
    chk("ex_valid", ex_valid, m.valid);
    chk("bubble_cnt", bubble_cnt, 16'(m.bubbles));
  endtask
  task automatic randomInputs();
    {RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, lui, jump, ALUOp} = 13'($urandom);
    ReadData1 = $urandom; ReadData2 = $urandom; SignExtImm = $urandom; PC_4 = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
    id_valid = 1'b1; flush = 1'b0; stall_in = 1'b0; reset = 1'b0;
  endtask
  initial begin
    int saved;
    randomInputs();
    reset = 1'b1; id_rs = 5'd9; id_rt = 5'd9;
    cycle(); cycle();
    #1;
    chk("rst_pcwrite", PCWrite, 1'b1);
    chk("rst_ififwrite", IFIDWrite, 1'b1);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_rd1", ReadData1_ex, 32'h0);
    chk("rst_bubbles", bubble_cnt, 16'h0);
    @(negedge clk);
    randomInputs();
    RegWrite = 1'b1; ALUOp = 3'b111; ReadData1 = 32'hDEADBEEF; MemRead = 1'b0;
    cycle();
    chk("cap_regwrite", RegWrite_ex, 1'b1);
    chk("cap_aluop", ALUOp_ex, 3'b111);
    chk("cap_rd1", ReadData1_ex, 32'hDEADBEEF);
    chk("cap_valid", ex_valid, 1'b1);
    randomInputs();
    MemRead = 1'b1; id_rt = 5'd8; RegWrite = 1'b1;
    cycle();
    randomInputs();
    id_rs = 5'd8; id_rt = 5'd3; MemRead = 1'b0; RegWrite = 1'b1;
    #1;
    chk("lu_pcwrite", PCWrite, !HZ);
    chk("lu_ifidwrite", IFIDWrite, !HZ);
    cycle();
    chk("lu_regwrite", RegWrite_ex, !HZ);
    chk("lu_valid", ex_valid, !HZ);
    chk("lu_bubbles", bubble_cnt, HZ ? 16'd1 : 16'd0);
    #1;
    chk("lu_after_pcwrite", PCWrite, 1'b1);
    cycle();
    randomInputs();
    MemRead = 1'b1; id_rt = 5'd0;
    cycle();
    saved = bubble_cnt;
    randomInputs();
    id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk("rt0_pcwrite", PCWrite, 1'b1);
    cycle();
    chk("rt0_bubbles", bubble_cnt, 16'(saved));
    randomInputs();
    MemRead = 1'b1; id_rt = 5'd8;
    cycle();
    randomInputs();
    id_rs = 5'd8; flush = 1'b1;
    #1;
    chk("fl_pcwrite", PCWrite, 1'b1);
    cycle();
    chk("fl_valid", ex_valid, 1'b0);
    chk("fl_bubbles", bubble_cnt, 16'(saved));
    randomInputs();
    flush = 1'b1; stall_in = 1'b1; ReadData1 = 32'h12345678;
    #1;
    chk("flst_pcwrite", PCWrite, 1'b1);
    cycle();
    chk("flst_valid", ex_valid, 1'b0);
    chk("flst_rd1", ReadData1_ex, 32'h12345678);
    randomInputs();
    stall_in = 1'b1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      randomInputs();
      MemRead = ($urandom_range(0, 2) != 0);
      id_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
`ifdef HAZARD_DETECT_EN
    randomInputs();
    reset = 1'b1;
    cycle();
    randomInputs();
    force dut.bubble_cnt = 16'hFFFE;
    #1;
    release dut.bubble_cnt;
    m.bubbles = 65534;
    for (int i = 0; i < 3; i++) begin
      randomInputs();
      MemRead = 1'b1; id_rt = 5'd5;
      cycle();
      randomInputs();
      id_rs = 5'd5;
      cycle();
    end
    chk("sat_bubbles", bubble_cnt, 16'hFFFF);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have ports: clk in 1 rising-edge clock; reset in 1 synchronous active-high reset.
REQ-002 SHALL have decode-control inputs from the control unit: RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, lui, jump (in 1 each); ALUOp in 3.
REQ-003 SHALL have decode-data inputs: id_valid in 1 (ID holds a real instruction); id_rs, id_rt, id_rd in 5; ReadData1, ReadData2, SignExtImm, PC_4 in 32.
REQ-004 SHALL have pipeline inputs: flush in 1 (branch/jump taken, kill ID); stall_in in 1 (downstream hold).
REQ-005 SHALL have registered outputs: every REQ-002/REQ-003 signal with suffix _ex (same width), plus ex_valid out 1.
REQ-006 SHALL have outputs: PCWrite out 1, IFIDWrite out 1 (combinational front-end enables); bubble_cnt out 16 (saturating inserted-bubble count).

Function
REQ-007 SHALL update all _ex registers only on rising clk; per-cycle action chosen by priority reset > flush > stall_in > hazard > capture.
REQ-008 Capture: all _ex outputs SHALL take their ID inputs; ex_valid SHALL take id_valid; latency one cycle.
REQ-009 Hazard SHALL be asserted when MemRead_ex=1 and ex_valid=1 and id_valid=1 and rt_ex!=0 and (rt_ex==id_rs or rt_ex==id_rt).
REQ-010 Hazard cycle: control _ex outputs (REQ-002 set) and ex_valid SHALL load 0; data _ex outputs SHALL capture ID inputs; PCWrite=0, IFIDWrite=0 same cycle.
REQ-011 Hazard SHALL last exactly one cycle per load-use pair, since the bubble clears MemRead_ex.
REQ-012 Flush: control _ex outputs and ex_valid SHALL load 0; data _ex outputs SHALL capture ID inputs; PCWrite=1, IFIDWrite=1; hazard ignored that cycle.
REQ-013 stall_in=1 without flush: all _ex registers SHALL hold; PCWrite=0, IFIDWrite=0; bubble_cnt unchanged.
REQ-014 Outside hazard/stall_in, PCWrite and IFIDWrite SHALL be 1.
REQ-015 bubble_cnt SHALL increment by 1 on each hazard-bubble cycle (REQ-010 taken), saturate at 16'hFFFF, never wrap; flush bubbles SHALL NOT count.
REQ-016 id_valid=0 in capture SHALL still capture control inputs but set ex_valid=0; downstream qualifies with ex_valid.

Reset
REQ-017 While reset=1 at a clk edge, all _ex outputs, ex_valid and bubble_cnt SHALL load 0.
REQ-018 During reset PCWrite and IFIDWrite SHALL be 1; first capture SHALL occur on the first edge with reset=0.
REQ-019 Reset asserted mid-stall or mid-hazard SHALL override both; no state survives.

Configuration
REQ-020 Macro HAZARD_DETECT_EN SHALL control load-use detection.
REQ-021 Defined: REQ-009..REQ-011 and REQ-015 active as written.
REQ-022 Undefined: hazard SHALL be constant 0, bubble_cnt SHALL be constant 0, PCWrite/IFIDWrite depend only on stall_in; flush, stall_in, reset unchanged.

Verification
REQ-023 Reset: reset=1 two edges with nonzero inputs -> all _ex=0, ex_valid=0, bubble_cnt=0, PCWrite=IFIDWrite=1.
REQ-024 Capture: id_valid=1, RegWrite=1, ALUOp=3'b111, ReadData1=32'hDEADBEEF -> next edge RegWrite_ex=1, ALUOp_ex=3'b111, ReadData1_ex=32'hDEADBEEF, ex_valid=1.
REQ-025 Load-use: capture lw (MemRead=1, id_rt=5'd8), next ID id_rs=5'd8 -> PCWrite=IFIDWrite=0 one cycle, next edge RegWrite_ex=0, ex_valid=0, bubble_cnt=1; following cycle PCWrite=1.
REQ-026 rt zero: MemRead_ex=1, rt_ex=0, id_rs=0 -> no hazard, PCWrite=1, bubble_cnt unchanged.
REQ-027 Flush vs hazard: hazard condition and flush=1 same cycle -> ex_valid=0, PCWrite=1, bubble_cnt unchanged; flush with stall_in=1 -> flush wins.
REQ-028 Saturation: preload 65535 hazard bubbles, one more hazard -> bubble_cnt stays 16'hFFFF; build without HAZARD_DETECT_EN, REQ-025 stimulus -> PCWrite=1, bubble_cnt=0.
